pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor, successor to the fixed 16-bit combinational full adder.
- Splits a WIDTH-bit add into STAGES equal chunks, one chunk per clock, carry registered between stages.
- Valid/ready handshake on both sides, so it can sit in the RISC-V datapath or feed a multi-cycle ALU without a timing-critical full-width carry chain.

---
 rtl/pipelined_adder.sv | 126 ++++++++++++
 tb/tb_pipelined_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks, one chunk per clock.
// Define PIPELINED_ADDER_FLAGS_EN to add the registered zero and ovf result flags.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PIPELINED_ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK       = WIDTH / SAFE_STAGES;

  if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = c_in ^ sub;

  // The word register rotates right by one chunk per stage: the low chunk is the
  // next operand chunk of a, and finished sum chunks are inserted at the top, so
  // after the last stage the word holds the complete, aligned sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BW = WIDTH - k * CHUNK;

    logic [WIDTH-1:0] src_word;
    logic [BW-1:0]    src_b;
    logic             src_c;
    logic             src_v;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] word_q;
    logic             carry_q;
    logic             valid_q;

    if (k == 0) begin : g_src
      assign src_word = a;
      assign src_b    = b_eff;
      assign src_c    = cin_eff;
      assign src_v    = in_valid;
    end else begin : g_src
      assign src_word = g_stage[k-1].word_q;
      assign src_b    = g_stage[k-1].g_fwd.b_q;
      assign src_c    = g_stage[k-1].carry_q;
      assign src_v    = g_stage[k-1].valid_q;
    end

    assign chunk_sum = {1'b0, src_word[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, src_c};

    if (STAGES == 1) begin : g_rot
      assign next_word = chunk_sum[CHUNK-1:0];
    end else begin : g_rot
      assign next_word = {chunk_sum[CHUNK-1:0], src_word[WIDTH-1:CHUNK]};
    end

    // Data only loads for valid slots, so bubbles leave the last result untouched.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        word_q  <= '0;
        carry_q <= 1'b0;
      end else if (adv) begin
        valid_q <= src_v;
        if (src_v) begin
          word_q  <= next_word;
          carry_q <= chunk_sum[CHUNK];
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [BW-CHUNK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          b_q <= '0;
        end else if (adv && src_v) begin
          b_q <= src_b[BW-1:CHUNK];
        end
      end
    end

`ifdef PIPELINED_ADDER_FLAGS_EN
    if (k == STAGES - 1) begin : g_flags
      // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          zero <= 1'b0;
          ovf  <= 1'b0;
        end else if (adv && src_v) begin
          zero <= (next_word == '0);
          ovf  <= src_word[CHUNK-1] ^ src_b[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
        end
      end
    end
`endif
  end

  assign sum       = g_stage[STAGES-1].word_q;
  assign c_out     = g_stage[STAGES-1].carry_q;
  assign out_valid = g_stage[STAGES-1].valid_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: a 4-stage and a 1-stage 16-bit adder share stimulus, each
// scored against an arithmetic reference model with per-beat latency tracking.
module tb_pipelined_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        zero;
    logic        ovf;
    int          stamp;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             out_ready;
  logic [15:0]      a;
  logic [15:0]      b;
  logic             c_in;
  logic             sub;
  logic [1:0]       in_ready_v;
  logic [1:0]       out_valid_v;
  logic [1:0]       c_out_v;
  logic [1:0][15:0] sum_v;
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic [1:0]       zero_v;
  logic [1:0]       ovf_v;
`endif

  int checks = 0;
  int errors = 0;
  int pending [2];

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .sum(sum_v[0]), .c_out(c_out_v[0])
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .zero(zero_v[0]), .ovf(ovf_v[0])
`endif
  );

  pipelined_adder #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .sum(sum_v[1]), .c_out(c_out_v[1])
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .zero(zero_v[1]), .ovf(ovf_v[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer add/subtract; carry means "no borrow" when subtracting.
  function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs);
    exp_t r;
    int   u;
    int   s;
    if (vs) begin
      u      = int'(va) - int'(vb) - int'(vc);
      s      = int'($signed(va)) - int'($signed(vb)) - int'(vc);
      r.cout = (u >= 0);
    end else begin
      u      = int'(va) + int'(vb) + int'(vc);
      s      = int'($signed(va)) + int'($signed(vb)) + int'(vc);
      r.cout = (u > 65535);
    end
    r.sum   = u[15:0];
    r.zero  = (r.sum == 16'h0000);
    r.ovf   = (s > 32767) || (s < -32768);
    r.stamp = 0;
    return r;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_mon
    localparam int DEPTH = (d == 0) ? 4 : 1;
    exp_t        q [$];
    exp_t        e;
    int          adv_count = 0;
    logic        hold = 1'b0;
    logic [15:0] hold_sum;
    logic        hold_cout;

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        hold = 1'b0;
      end else begin
        checkOutput($sformatf("s%0d_in_ready", DEPTH), 32'(in_ready_v[d]), 32'(!out_valid_v[d] || out_ready));
        if (hold) begin
          checkOutput($sformatf("s%0d_stall_valid", DEPTH), 32'(out_valid_v[d]), 32'd1);
          checkOutput($sformatf("s%0d_stall_sum", DEPTH), 32'(sum_v[d]), 32'(hold_sum));
          checkOutput($sformatf("s%0d_stall_cout", DEPTH), 32'(c_out_v[d]), 32'(hold_cout));
        end
        if (out_valid_v[d] && out_ready) begin
          if (q.size() == 0) begin
            checkOutput($sformatf("s%0d_spurious", DEPTH), 32'(out_valid_v[d]), 32'd0);
          end else begin
            e = q.pop_front();
            checkOutput($sformatf("s%0d_sum", DEPTH), 32'(sum_v[d]), 32'(e.sum));
            checkOutput($sformatf("s%0d_cout", DEPTH), 32'(c_out_v[d]), 32'(e.cout));
            checkOutput($sformatf("s%0d_latency", DEPTH), 32'(adv_count - e.stamp), 32'(DEPTH));
`ifdef PIPELINED_ADDER_FLAGS_EN
            checkOutput($sformatf("s%0d_zero", DEPTH), 32'(zero_v[d]), 32'(e.zero));
            checkOutput($sformatf("s%0d_ovf", DEPTH), 32'(ovf_v[d]), 32'(e.ovf));
`endif
          end
        end
        if (in_valid && in_ready_v[d]) begin
          e       = model(a, b, c_in, sub);
          e.stamp = adv_count;
          q.push_back(e);
        end
        if (!out_valid_v[d] || out_ready) adv_count++;
        hold      = out_valid_v[d] && !out_ready;
        hold_sum  = sum_v[d];
        hold_cout = c_out_v[d];
      end
      pending[d] = q.size();
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one beat and holds it until the 4-stage instance accepts it.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs);
    logic ok;
    int   waited;
    a        = va;
    b        = vb;
    c_in     = vc;
    sub      = vs;
    in_valid = 1'b1;
    waited   = 0;
    do begin
      @(negedge clk);
      ok = in_ready_v[0];
      @(posedge clk);
      #1;
      waited++;
    end while (!ok && waited < 50);
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    pending   = '{0, 0};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_out_valid", 32'(out_valid_v[d]), 32'd0);
      checkOutput("reset_sum", 32'(sum_v[d]), 32'd0);
      checkOutput("reset_cout", 32'(c_out_v[d]), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready_v[d]), 32'd1);
`ifdef PIPELINED_ADDER_FLAGS_EN
      checkOutput("reset_zero", 32'(zero_v[d]), 32'd0);
      checkOutput("reset_ovf", 32'(ovf_v[d]), 32'd0);
`endif
    end
    @(posedge clk);
    #1;

    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
    idle(6);

    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    idle(6);

    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    idle(6);

    fork
      begin
        for (int i = 1; i <= 6; i++) applyStimulus(16'(i), 16'(i), 1'b0, 1'b0);
      end
      begin
        idle(5);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(8);

    for (int i = 0; i < 3; i++) applyStimulus(16'(16'h1000 + i), 16'h0111, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_s4_out_valid", 32'(out_valid_v[0]), 32'd0);
    checkOutput("midreset_s1_out_valid", 32'(out_valid_v[1]), 32'd0);
    @(posedge clk);
    #1;
    idle(8);

    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      begin
        repeat (200) begin
          out_ready = ($urandom_range(0, 2) != 0);
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    idle(10);

    checkOutput("s4_leftover", 32'(pending[0]), 32'd0);
    checkOutput("s1_leftover", 32'(pending[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
